seg_scan_ctrl: RTL

- Parametrised N-digit multiplexed seven-segment scan controller.
- Takes packed BCD/hex digits plus per-digit decimal-point, blank and dash flags, and drives one shared segment bus with per-digit selects.
- Adds tear-free frame-synchronous updates, leading-zero suppression, an anti-ghosting guard interval, PWM brightness and configurable output polarity.
- Sits between counting/timekeeping cores (stopwatch, timer, counter) and the board's display pins.

---
 rtl/seg_scan_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Drives one shared segment bus plus one-hot digit selects. Digit data is
// double buffered so that updates take effect only at a frame boundary.
// Leading-zero suppression, an anti-ghosting guard at the start of every slot,
// PWM dimming and output polarity are also handled here.
module seg_scan_ctrl #(
  parameter int NUM_DIG     = 8,
  parameter int SCAN_DIV    = 125000,
  parameter int GUARD       = 16,
  parameter int DIM_W       = 4,
  parameter bit SEL_ACT_LOW = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [4*NUM_DIG-1:0]   digit_i,
  input  logic [NUM_DIG-1:0]     dp_i,
  input  logic [NUM_DIG-1:0]     blank_i,
  input  logic [NUM_DIG-1:0]     dash_i,
  input  logic                   upd,
  input  logic                   lzs_en,
  input  logic [DIM_W-1:0]       bright,
  output logic [NUM_DIG-1:0]     seg_sel,
  output logic [7:0]             seg_led,
  output logic                   frame_tick,
  output logic                   upd_pend
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIG);
  localparam int SHW   = 7 * NUM_DIG;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIG - 1);

  // Shadow layout: {dash, blank, dp, digits}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIM_W-1:0]   pwm_q, pwm_d;
  logic [SHW-1:0]     pend_q, pend_d;
  logic [SHW-1:0]     act_q, act_d;
  logic               upd_pend_q, upd_pend_d;
  logic [NUM_DIG-1:0] sel_q, sel_d;
  logic [7:0]         led_q, led_d;
  logic               tick_q, tick_d;

  logic               slot_wrap;
  logic               frame_bnd;
  logic [SHW-1:0]     in_vec;
  logic [4*NUM_DIG-1:0] act_dig;
  logic [NUM_DIG-1:0] act_dp, act_blank, act_dash;
  logic [NUM_DIG-1:0] supp;
  logic               lzs_run;
  logic [3:0]         cur_dig;
  logic [6:0]         seg7;
  logic               lit;

  assign in_vec    = {dash_i, blank_i, dp_i, digit_i};
  assign act_dig   = act_q[4*NUM_DIG-1:0];
  assign act_dp    = act_q[5*NUM_DIG-1:4*NUM_DIG];
  assign act_blank = act_q[6*NUM_DIG-1:5*NUM_DIG];
  assign act_dash  = act_q[7*NUM_DIG-1:6*NUM_DIG];

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot counter, scan index and free-running PWM counter
  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    frame_bnd = slot_wrap && (idx_q == IDX_LAST);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Double buffer: upd fills pending, frame boundary promotes it to active;
  // an upd on the boundary cycle itself bypasses pending entirely
  always_comb begin
    pend_d     = pend_q;
    act_d      = act_q;
    upd_pend_d = upd_pend_q;
    if (upd) begin
      if (frame_bnd) begin
        act_d      = in_vec;
        upd_pend_d = 1'b0;
      end else begin
        pend_d     = in_vec;
        upd_pend_d = 1'b1;
      end
    end else if (frame_bnd && upd_pend_q) begin
      act_d      = pend_q;
      upd_pend_d = 1'b0;
    end
  end

  // Leading-zero suppression: walk down from the top digit until the first
  // digit that carries anything visible; digit 0 always stays lit
  always_comb begin
    lzs_run = lzs_en;
    supp    = '0;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      lzs_run = lzs_run && (act_dig[4*k +: 4] == 4'h0) && !act_dp[k]
                && !act_dash[k] && !act_blank[k];
      supp[k] = lzs_run;
    end
  end

  // Next output values for the current slot (registered below)
  always_comb begin
    cur_dig = act_dig[{idx_q, 2'b00} +: 4];
    if (act_dash[idx_q]) begin
      seg7 = 7'h40;
    end else if (supp[idx_q]) begin
      seg7 = 7'h00;
    end else begin
      seg7 = hex_decode(cur_dig);
    end
    led_d = act_blank[idx_q] ? 8'h00 : {act_dp[idx_q], seg7};

    lit = (cnt_q >= CNT_GUARD) && ((bright == '1) || (pwm_q < bright));
    sel_d        = '0;
    sel_d[idx_q] = lit;

    tick_d = (cnt_q == '0) && (idx_q == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      upd_pend_q <= 1'b0;
      sel_q      <= '0;
      led_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      upd_pend_q <= upd_pend_d;
      sel_q      <= sel_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
    end
  end

  assign seg_sel    = SEL_ACT_LOW ? ~sel_q : sel_q;
  assign seg_led    = SEG_ACT_LOW ? ~led_q : led_q;
  assign frame_tick = tick_q;
  assign upd_pend   = upd_pend_q;

endmodule
